// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-frame, read-only instruction cache.
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr  fetch request and byte address from the datapath
//   ihit, imemload     same-cycle hit flag and instruction word (0 on miss)
//   iREN, iaddr        memory read request and word-aligned address
//   iwait, iload       memory busy flag and read data (valid when iwait = 0)
module icache_direct #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 30 - IDX;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            r_state, w_next;
    logic [SETS-1:0]   r_valid;
    logic [TAG-1:0]    r_tag  [SETS];
    logic [31:0]       r_data [SETS];
    logic [29:0]       r_miss;
    logic [IDX-1:0]    w_idx, w_fidx;
    logic [TAG-1:0]    w_tag;
    logic              w_fill, w_miss;
    logic [1:0]        w_unused;

    assign w_unused = imemaddr[1:0];
    assign w_idx    = imemaddr[IDX+1:2];
    assign w_tag    = imemaddr[31:IDX+2];
    assign w_fidx   = r_miss[IDX-1:0];

    // Hit is evaluated against the current fetch address, so a fill for an
    // abandoned address can never produce a false hit.
    assign ihit     = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign imemload = ihit ? r_data[w_idx] : '0;

    always_comb begin
        w_next = r_state;
        iREN   = 1'b0;
        iaddr  = '0;
        w_fill = 1'b0;
        w_miss = 1'b0;
        if (r_state == IDLE) begin
            w_miss = imemREN & ~ihit;
            if (w_miss) w_next = FETCH;
        end else begin
            iREN   = 1'b1;
            iaddr  = {r_miss, 2'b00};
            w_fill = ~iwait;
            if (w_fill) w_next = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_miss  <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss) r_miss <= imemaddr[31:2];
            if (w_fill) r_valid[w_fidx] <= 1'b1;
        end
    end

    // Tag/data need no reset: the valid bit guards every read.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fidx]  <= r_miss[29:IDX];
            r_data[w_fidx] <= iload;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed and randomized checks of icache_direct against a behavioural model.
module tb_icache_direct;
    localparam int SETS = 16;
    localparam int IDX  = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;

    int errors = 0;
    int checks = 0;

    icache_direct #(.SETS(SETS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    // Model: cache contents by frame number plus one outstanding fill request.
    bit          m_valid [SETS];
    int unsigned m_tag   [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_pend;
    logic [31:0] m_addr;

    function automatic int unsigned frame_of(logic [31:0] a);
        return (a >> 2) % SETS;
    endfunction

    function automatic int unsigned tag_of(logic [31:0] a);
        return a >> (2 + IDX);
    endfunction

    function automatic bit m_hit(logic [31:0] a, logic ren);
        return ren && m_valid[frame_of(a)] && m_tag[frame_of(a)] == tag_of(a);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) m_valid[i] <= 1'b0;
            m_pend <= 1'b0;
        end else if (m_pend) begin
            if (!iwait) begin
                m_valid[frame_of(m_addr)] <= 1'b1;
                m_tag[frame_of(m_addr)]   <= tag_of(m_addr);
                m_data[frame_of(m_addr)]  <= iload;
                m_pend <= 1'b0;
            end
        end else if (imemREN && !m_hit(imemaddr, imemREN)) begin
            m_pend <= 1'b1;
            m_addr <= imemaddr & 32'hFFFF_FFFC;
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        logic eh;
        eh = m_hit(imemaddr, imemREN);
        chk("m_ihit", {31'b0, ihit}, {31'b0, eh});
        chk("m_imemload", imemload, eh ? m_data[frame_of(imemaddr)] : 32'h0);
        chk("m_iREN", {31'b0, iREN}, {31'b0, m_pend});
        if (m_pend) chk("m_iaddr", iaddr, m_addr);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] d, input int w, input bit drop);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
        @(negedge CLK);
        chk("miss_ihit", {31'b0, ihit}, 32'd0);
        chk("miss_iREN_idle", {31'b0, iREN}, 32'd0);
        step();
        if (drop) imemREN = 1'b0;
        repeat (w) begin
            @(negedge CLK);
            chk("wait_iREN", {31'b0, iREN}, 32'd1);
            chk("wait_iaddr", iaddr, a & 32'hFFFF_FFFC);
            chk("wait_ihit", {31'b0, ihit}, 32'd0);
            step();
        end
        iwait = 1'b0; iload = d;
        @(negedge CLK);
        chk("fill_iREN", {31'b0, iREN}, 32'd1);
        chk("fill_iaddr", iaddr, a & 32'hFFFF_FFFC);
        chk("fill_ihit", {31'b0, ihit}, 32'd0);
        step();
        iwait = 1'b1; iload = 32'hDEAD_BEEF;
    endtask

    task automatic look(input logic [31:0] a, input logic [31:0] d);
        imemREN = 1'b1; imemaddr = a;
        @(negedge CLK);
        chk("hit_ihit", {31'b0, ihit}, 32'd1);
        chk("hit_data", imemload, d);
        chk("hit_iREN", {31'b0, iREN}, 32'd0);
        step();
    endtask

    initial begin
        #2;
        @(negedge CLK);
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_iREN", {31'b0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        step();
        nRST = 1'b1;
        step();

        // Cold miss, then hit stream.
        fill(32'h0, 32'h8C01_0004, 2, 1'b0);
        look(32'h0, 32'h8C01_0004);
        fill(32'h4, 32'h1111_0004, 1, 1'b0);
        fill(32'h8, 32'h2222_0008, 0, 1'b0);
        look(32'h0, 32'h8C01_0004);
        look(32'h4, 32'h1111_0004);
        look(32'h8, 32'h2222_0008);

        // Conflict eviction on frame 0.
        fill(32'h40, 32'hBBBB_BBBB, 1, 1'b0);
        look(32'h40, 32'hBBBB_BBBB);
        fill(32'h0, 32'hAAAA_AAAA, 1, 1'b0);
        look(32'h0, 32'hAAAA_AAAA);

        // Unaligned top address wraps into the last frame.
        fill(32'hFFFF_FFFE, 32'h0, 1, 1'b0);
        look(32'hFFFF_FFFC, 32'h0);

        // Abandoned fetch still commits.
        fill(32'h10, 32'h1234, 2, 1'b1);
        look(32'h10, 32'h1234);

        // Reset while a fill is outstanding.
        imemREN = 1'b1; imemaddr = 32'h20; iwait = 1'b1;
        step();
        @(negedge CLK);
        chk("pre_rst_iREN", {31'b0, iREN}, 32'd1);
        #1 nRST = 1'b0;
        #1 chk("async_rst_iREN", {31'b0, iREN}, 32'd0);
        step();
        nRST = 1'b1;
        imemaddr = 32'h0;
        @(negedge CLK);
        chk("post_rst_miss", {31'b0, ihit}, 32'd0);
        step();
        iwait = 1'b0; iload = 32'h5555_0000;
        step();
        iwait = 1'b1;
        look(32'h0, 32'h5555_0000);

        // Randomized traffic over a small address pool to force hits and conflicts.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 9) == 0)
                    imemaddr = 32'hFFFF_FFC0 | $urandom_range(0, 63);
                else
                    imemaddr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                             | $urandom_range(0, 3);
            end
            imemREN = ($urandom_range(0, 4) != 0);
            iwait   = ($urandom_range(0, 1) == 0);
            iload   = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                nRST = 1'b0;
                #2 nRST = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-frame, read-only instruction cache between the pipeline's instruction fetch port and the memory controller's instruction port.
- Serves the PC fetch in the same cycle on a hit (ihit, imemload).
- On a miss, runs a single-word fill from memory, writes the frame, then hits on the following cycle.
- The pipeline stalls its PC and fetch latch while ihit is low.

Parameters:
- SETS, 16, number of frames; power of two, at least 2. IDX = log2(SETS); TAG = 30 - IDX.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- imemREN  input  1  fetch request from datapath
- imemaddr  input  32  fetch byte address; bits[1:0] ignored
- ihit  output  1  imemload valid for imemaddr this cycle
- imemload  output  32  instruction word
- iREN  output  1  memory read request
- iaddr  output  32  memory word address, bits[1:0] = 0
- iwait  input  1  memory busy; low = iload valid this cycle
- iload  input  32  memory read data

Behaviour:
- Reset and clocking:
  - One clock, CLK.
  - Reset is asynchronous and active-low on nRST.
- Address split:
  - index = imemaddr[IDX+1:2]
  - tag = imemaddr[31:IDX+2]
- Storage:
  - Per frame: valid (1), tag (TAG), data (32).
  - Valid bits have async reset. Tag and data arrays need no reset.
- Reset values:
  - All valid = 0; state = IDLE.
  - ihit = 0, iREN = 0, iaddr = 0, imemload = 0.
- Hit (combinational, any state):
  - ihit = imemREN & valid[index] & (tag[index] == tag).
  - imemload = data[index] when ihit, else 0.
- FSM, two states:
  - IDLE:
    - iREN = 0.
    - If imemREN & !ihit: capture miss_addr = {imemaddr[31:2], 2'b00} into a register; next = FETCH.
    - Otherwise stay in IDLE.
  - FETCH:
    - iREN = 1, iaddr = miss_addr.
    - While iwait = 1: stay in FETCH; the request is held stable.
    - When iwait = 0: on that edge, write frame[miss_addr index] with valid = 1, tag = miss_addr tag, data = iload; next = IDLE.
- Latency:
  - Hit: 0 cycles.
  - Miss: 1 cycle (IDLE detect) + N wait cycles + 1 fill edge. ihit rises in the cycle after the fill edge, provided imemaddr is unchanged.
  - No bypass of iload to imemload during the fill.
- Fill commitment:
  - The fill completes and is written even if imemREN drops or imemaddr changes during FETCH.
  - ihit always reflects the current imemaddr against array contents, so a stale fill never produces a false hit.
- Conflicts:
  - A fill overwrites the frame unconditionally. There is no dirty state and no writeback.
  - Addresses differing only in tag evict each other.
- ihit in FETCH:
  - Hits to other valid frames may still assert ihit while FETCH is active. The datapath ignores this because it is stalled on the original address.
  - Combinational ihit is permitted.
- Reset mid-FETCH:
  - Return to IDLE immediately, iREN = 0, all frames invalid.
  - No partial write occurs.
- Address wrap:
  - 0xFFFFFFFC is a legal address; its index is SETS-1 and its tag is all ones.
- Prohibited behaviour:
  - Never issue iREN in IDLE.
  - Never change iaddr while iREN = 1 and iwait = 1.
- Simultaneous events: an iwait=0 edge and a new imemREN miss in the same cycle are handled in order: the fill completes, the FSM goes to IDLE, and the new miss is detected next cycle.

Test Plan:
- Cold miss:
  - Stimulus: reset, imemREN = 1, imemaddr = 0x00000000; memory holds iwait = 1 for 2 cycles, then iwait = 0 with iload = 0x8C010004.
  - Required: ihit = 0 throughout; iREN = 1 and iaddr = 0x0 for 3 cycles; then ihit = 1 and imemload = 0x8C010004 next cycle; iREN = 0.
- Hit stream:
  - Stimulus: addresses 0x0, 0x4, 0x8 after all three are filled.
  - Required: ihit = 1 each cycle, correct data, iREN stays 0.
- Conflict eviction (SETS = 16):
  - Stimulus: fill 0x00000000 (data A), then 0x00000040 (data B, same index 0); re-request 0x0.
  - Required: 0x40 misses then hits with B; the re-request of 0x0 misses and refills A.
- Unaligned and wrap:
  - Stimulus: imemaddr = 0xFFFFFFFE, fill with 0x00000000.
  - Required: iaddr = 0xFFFFFFFC; frame 15 is filled; a subsequent 0xFFFFFFFC hits.
- Abandoned fetch:
  - Stimulus: miss on 0x10; imemREN drops to 0 during FETCH; iwait = 0 with iload = 0x1234.
  - Required: fill still written; re-request of 0x10 gives ihit = 1 and imemload = 0x1234 with no new iREN.
- Reset mid-FETCH:
  - Stimulus: assert nRST = 0 while iREN = 1.
  - Required: iREN = 0 asynchronously; after release, previously filled 0x0 misses again.
